// File: rtl/usb_ls_host_if_if.sv
// CPU register bus and PHY toggle-handshake signals of the low-speed USB host bridge.
interface usb_ls_host_if_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;
  logic [15:0] phy_din;
  logic        phy_wrin;
  logic        phy_wrout;
  logic        phy_rdin;
  logic        phy_rdout;
  logic [15:0] phy_dout;
  logic        phy_soft_reset;

  // Bridge side: serves the CPU and drives the PHY handshakes.
  modport slave (
    input  sel, we, addr, wdata, phy_wrout, phy_rdout, phy_dout,
    output rdata, irq, phy_din, phy_wrin, phy_rdin, phy_soft_reset
  );

  // Environment side: the CPU and the PHY engine.
  modport master (
    output sel, we, addr, wdata, phy_wrout, phy_rdout, phy_dout,
    input  rdata, irq, phy_din, phy_wrin, phy_rdin, phy_soft_reset
  );
endinterface

// File: rtl/usb_ls_host_if.sv
// CPU-side bridge to the low-speed USB PHY engine: TX/RX word FIFOs, register file and a
// toggle-handshake engine with timeout recovery and PHY soft reset.
module usb_ls_host_if #(
  parameter int unsigned TX_DEPTH_LOG2   = 4,
  parameter int unsigned RX_DEPTH_LOG2   = 4,
  parameter int unsigned ACK_TIMEOUT     = 65535,
  parameter int unsigned SOFT_RST_CYCLES = 255
) (
  input logic             clk,
  input logic             reset_n,
  usb_ls_host_if_if.slave bus
);

  localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
  localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;
  localparam int unsigned TxCntW  = TX_DEPTH_LOG2 + 1;
  localparam int unsigned RxCntW  = RX_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    StIdle, StTxReq, StTxWait, StRxReq, StRxWait, StSrst
  } state_e;

  state_e state_q, state_d;

  // CPU access decode
  logic wr_en, rd_en, cpu_push, cpu_pop, ctrl_wr, flush_req, flag_clr;
  assign wr_en     = bus.sel & bus.we;
  assign rd_en     = bus.sel & ~bus.we;
  assign cpu_push  = wr_en & (bus.addr == 2'd0);
  assign cpu_pop   = rd_en & (bus.addr == 2'd0);
  assign ctrl_wr   = wr_en & (bus.addr == 2'd2);
  assign flush_req = ctrl_wr & bus.wdata[3];
  assign flag_clr  = ctrl_wr & bus.wdata[2];

  // Engine strobes
  logic tx_pop, rx_push_req, tmo_set, srst_done, srst_take;

  // TX FIFO
  logic [15:0]              tx_mem [TxDepth];
  logic [TX_DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q, tx_waddr;
  logic [TxCntW-1:0]        tx_cnt_q;
  logic                     tx_empty, tx_full, tx_push, tx_flush;
  logic [15:0]              tx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TxCntW'(TxDepth));
  assign tx_push  = cpu_push & ~tx_full;
  assign tx_flush = flush_req | srst_done;
  assign tx_waddr = tx_flush ? '0 : tx_wptr_q;
  assign tx_head  = tx_mem[tx_rptr_q];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_waddr] <= bus.wdata;
  end

  // A flush coinciding with a push leaves just the new word in the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_flush) begin
      tx_wptr_q <= TX_DEPTH_LOG2'(tx_push);
      tx_rptr_q <= '0;
      tx_cnt_q  <= TxCntW'(tx_push);
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + TxCntW'(tx_push) - TxCntW'(tx_pop);
    end
  end

  // RX FIFO
  logic [15:0]              rx_mem [RxDepth];
  logic [RX_DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q, rx_waddr;
  logic [RxCntW-1:0]        rx_cnt_q;
  logic                     rx_empty, rx_full, rx_push, rx_pop, rx_flush;
  logic [15:0]              rx_head;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RxCntW'(RxDepth));
  assign rx_flush = flush_req | srst_done;
  assign rx_push  = rx_push_req & (~rx_full | rx_flush);
  assign rx_pop   = cpu_pop & ~rx_empty;
  assign rx_waddr = rx_flush ? '0 : rx_wptr_q;
  assign rx_head  = rx_mem[rx_rptr_q];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_waddr] <= bus.phy_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else if (rx_flush) begin
      rx_wptr_q <= RX_DEPTH_LOG2'(rx_push);
      rx_rptr_q <= '0;
      rx_cnt_q  <= RxCntW'(rx_push);
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + RxCntW'(rx_push) - RxCntW'(rx_pop);
    end
  end

  // Handshake engine
  logic [15:0] phy_din_q, phy_din_d;
  logic        wrin_q, wrin_d, rdin_q, rdin_d;
  logic [16:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  srst_cnt_q, srst_cnt_d;
  logic        soft_rst_q, soft_rst_d;
  logic        rx_enable_q, irq_en_q, srst_pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      phy_din_q  <= '0;
      wrin_q     <= 1'b0;
      rdin_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      srst_cnt_q <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phy_din_q  <= phy_din_d;
      wrin_q     <= wrin_d;
      rdin_q     <= rdin_d;
      tmo_cnt_q  <= tmo_cnt_d;
      srst_cnt_q <= srst_cnt_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phy_din_d   = phy_din_q;
    wrin_d      = wrin_q;
    rdin_d      = rdin_q;
    tmo_cnt_d   = tmo_cnt_q;
    srst_cnt_d  = srst_cnt_q;
    soft_rst_d  = soft_rst_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    tmo_set     = 1'b0;
    srst_done   = 1'b0;
    srst_take   = 1'b0;
    case (state_q)
      StIdle: begin
        if (srst_pend_q) begin
          state_d    = StSrst;
          srst_take  = 1'b1;
          soft_rst_d = 1'b1;
          srst_cnt_d = '0;
        end else if (!tx_empty) begin
          state_d = StTxReq;
        end else if (rx_enable_q && !rx_full) begin
          state_d = StRxReq;
        end
      end
      StTxReq: begin
        // A flush may have emptied the FIFO on the way in; nothing to send then.
        if (tx_empty) begin
          state_d = StIdle;
        end else begin
          phy_din_d = tx_head;
          tx_pop    = 1'b1;
          wrin_d    = ~wrin_q;
          tmo_cnt_d = '0;
          state_d   = StTxWait;
        end
      end
      StTxWait: begin
        if (bus.phy_wrout == wrin_q) begin
          state_d = StIdle;
        end else if (tmo_cnt_q == 17'(ACK_TIMEOUT)) begin
          tmo_set = 1'b1;
          wrin_d  = bus.phy_wrout;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 17'd1;
        end
      end
      StRxReq: begin
        rdin_d    = ~rdin_q;
        tmo_cnt_d = '0;
        state_d   = StRxWait;
      end
      StRxWait: begin
        if (bus.phy_rdout == rdin_q) begin
          rx_push_req = 1'b1;
          state_d     = StIdle;
        end else if (tmo_cnt_q == 17'(ACK_TIMEOUT)) begin
          tmo_set = 1'b1;
          rdin_d  = bus.phy_rdout;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 17'd1;
        end
      end
      StSrst: begin
        if (srst_cnt_q == 8'(SOFT_RST_CYCLES - 1)) begin
          soft_rst_d = 1'b0;
          wrin_d     = bus.phy_wrout;
          rdin_d     = bus.phy_rdout;
          srst_done  = 1'b1;
          state_d    = StIdle;
        end else begin
          srst_cnt_d = srst_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control, flags, interrupt and read data
  logic        ovf_q, unf_q, tmo_q, irq_q, busy;
  logic [7:0]  rx_count_sat;
  logic [15:0] status, ctrl_rb, rdata_q, rdata_d;

  assign busy         = (state_q != StIdle);
  assign rx_count_sat = (32'(rx_cnt_q) > 32'd255) ? 8'hFF : 8'(rx_cnt_q);
  assign status       = {rx_count_sat, tmo_q, unf_q, ovf_q, busy,
                         rx_full, rx_empty, tx_full, tx_empty};
  assign ctrl_rb      = {11'd0, irq_en_q, 2'b00, rx_enable_q, 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_enable_q <= 1'b0;
      irq_en_q    <= 1'b0;
      srst_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (ctrl_wr) begin
        rx_enable_q <= bus.wdata[1];
        irq_en_q    <= bus.wdata[4];
      end
      if (ctrl_wr && bus.wdata[0]) srst_pend_q <= 1'b1;
      else if (srst_take)          srst_pend_q <= 1'b0;
      ovf_q   <= (ovf_q & ~flag_clr) | (cpu_push & tx_full);
      unf_q   <= (unf_q & ~flag_clr) | (cpu_pop & rx_empty);
      tmo_q   <= (tmo_q & ~flag_clr) | tmo_set;
      irq_q   <= irq_en_q & (~rx_empty | tmo_q);
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (bus.addr)
        2'd0:    rdata_d = rx_empty ? 16'h0000 : rx_head;
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = ctrl_rb;
        default: rdata_d = bus.phy_dout;
      endcase
    end
  end

  assign bus.rdata          = rdata_q;
  assign bus.irq            = irq_q;
  assign bus.phy_din        = phy_din_q;
  assign bus.phy_wrin       = wrin_q;
  assign bus.phy_rdin       = rdin_q;
  assign bus.phy_soft_reset = soft_rst_q;

endmodule

// File: tb/tb_usb_ls_host_if.sv
// Directed bench for usb_ls_host_if with a toggle-handshake PHY model and TX/RX scoreboards.
module tb_usb_ls_host_if;

  localparam int unsigned TbAckTimeout = 300;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_ls_host_if_if bus ();

  usb_ls_host_if #(.ACK_TIMEOUT(TbAckTimeout)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboards: expected TX words, PHY-captured TX words, expected RX words, PHY RX source.
  logic [15:0] tx_exp [$];
  logic [15:0] cap_q  [$];
  logic [15:0] rx_exp [$];
  logic [15:0] rx_src [$];

  bit          wr_ack_en = 1'b0;
  bit          rd_ack_en = 1'b0;
  logic [15:0] link_code = 16'h1E80;
  int          n_wr_req = 0, n_resync = 0, n_srst_hi = 0;
  bit          din_unstable = 1'b0;

  // PHY model: acks write requests after 40 cycles, read requests after 5 cycles.
  initial begin
    logic        last_wrin;
    logic [15:0] held_din;
    int          wr_dly, rd_dly;
    last_wrin = 1'b0; held_din = '0; wr_dly = 0; rd_dly = 0;
    bus.phy_wrout = 1'b0;
    bus.phy_rdout = 1'b0;
    bus.phy_dout  = 16'h1E80;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        bus.phy_wrout = 1'b0;
        bus.phy_rdout = 1'b0;
        last_wrin = 1'b0; wr_dly = 0; rd_dly = 0;
      end else begin
        bus.phy_dout = link_code;
        if (bus.phy_soft_reset) n_srst_hi++;
        if (bus.phy_wrin != last_wrin) begin
          if (bus.phy_wrin != bus.phy_wrout) begin
            cap_q.push_back(bus.phy_din);
            held_din = bus.phy_din;
            n_wr_req++;
          end else begin
            n_resync++;
          end
          last_wrin = bus.phy_wrin;
          wr_dly = 0;
        end else if (bus.phy_wrin != bus.phy_wrout && bus.phy_din != held_din) begin
          din_unstable = 1'b1;
        end
        if (bus.phy_wrin != bus.phy_wrout && wr_ack_en) begin
          wr_dly++;
          if (wr_dly >= 40) begin
            bus.phy_wrout = bus.phy_wrin;
            wr_dly = 0;
          end
        end
        if (bus.phy_rdin != bus.phy_rdout && rd_ack_en && rx_src.size() > 0) begin
          rd_dly++;
          if (rd_dly >= 5) begin
            bus.phy_dout  = rx_src.pop_front();
            bus.phy_rdout = bus.phy_rdin;
            rd_dly = 0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0;
    d = bus.rdata;
  endtask

  initial begin
    logic [15:0] rd;
    int          n;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.rdata, 0);
    check("rst_irq", bus.irq, 0);
    check("rst_din", bus.phy_din, 0);
    check("rst_wrin", bus.phy_wrin, 0);
    check("rst_rdin", bus.phy_rdin, 0);
    check("rst_srst", bus.phy_soft_reset, 0);
    reset_n = 1'b1;
    cpu_read(2'd1, rd); check("rst_status", rd, 16'h0005);
    cpu_read(2'd2, rd); check("rst_ctrl", rd, 16'h0000);

    // Two TX words acked by the PHY
    wr_ack_en = 1'b1;
    cpu_write(2'd0, 16'h1234); tx_exp.push_back(16'h1234);
    cpu_write(2'd0, 16'hABCD); tx_exp.push_back(16'hABCD);
    n = 0;
    while (!(cap_q.size() == 2 && bus.phy_wrin == bus.phy_wrout) && n < 500) begin
      @(negedge clk); n++;
    end
    check("tx2_wait", n < 500, 1);
    repeat (3) @(negedge clk);
    check("tx2_cap_n", cap_q.size(), 2);
    while (cap_q.size() > 0 && tx_exp.size() > 0) check("tx2_word", cap_q.pop_front(), tx_exp.pop_front());
    check("tx2_toggles", n_wr_req, 2);
    check("tx2_wrin", bus.phy_wrin, 0);
    cpu_read(2'd1, rd); check("tx2_status", rd, 16'h0005);

    // RX: two words, then an unanswered request that times out
    rd_ack_en = 1'b1;
    rx_src.push_back(16'h00C3); rx_exp.push_back(16'h00C3);
    rx_src.push_back(16'h5A5A); rx_exp.push_back(16'h5A5A);
    cpu_write(2'd2, 16'h0012);
    n = 0;
    while (rx_src.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("rx_src_wait", n < 200, 1);
    n = 0;
    while (bus.phy_rdin == bus.phy_rdout && n < 50) begin @(negedge clk); n++; end
    check("rx_req3_wait", n < 50, 1);
    cpu_write(2'd2, 16'h0010);
    n = 0;
    while (bus.phy_rdin != bus.phy_rdout && n < 1000) begin @(negedge clk); n++; end
    check("rx_tmo_wait", n < 1000, 1);
    repeat (2) @(negedge clk);
    cpu_read(2'd1, rd); check("rx_status2", rd, 16'h0281);
    check("rx_irq_hi", bus.irq, 1);
    cpu_write(2'd2, 16'h0014);
    cpu_read(2'd2, rd); check("ctrl_rb", rd, 16'h0010);
    cpu_read(2'd0, rd); check("rx_word0", rd, rx_exp.pop_front());
    cpu_read(2'd1, rd); check("rx_status1", rd, 16'h0101);
    check("rx_irq_one", bus.irq, 1);
    cpu_read(2'd0, rd); check("rx_word1", rd, rx_exp.pop_front());
    cpu_read(2'd1, rd); check("rx_status0", rd, 16'h0005);
    check("rx_irq_lo", bus.irq, 0);

    // Underflow and flag clear
    cpu_read(2'd0, rd); check("unf_data", rd, 16'h0000);
    cpu_read(2'd1, rd); check("unf_status", rd, 16'h0045);
    cpu_write(2'd2, 16'h0014);
    cpu_read(2'd1, rd); check("unf_clr", rd, 16'h0005);

    // Overflow with a silent PHY, then TX timeout and resync
    wr_ack_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cpu_write(2'd0, 16'h1000 + 16'(i));
      if (i < 17) tx_exp.push_back(16'h1000 + 16'(i));
    end
    cpu_read(2'd1, rd); check("ovf_status", rd, 16'h0036);
    n = 0;
    while (!(n_resync == 1 && cap_q.size() == 2) && n < 1000) begin @(negedge clk); n++; end
    check("tmo_wait", n < 1000, 1);
    check("tmo_word0", cap_q.pop_front(), tx_exp.pop_front());
    check("tmo_pending", bus.phy_wrin != bus.phy_wrout, 1);
    cpu_read(2'd1, rd); check("tmo_status", rd, 16'h00B4);
    wr_ack_en = 1'b1;
    n = 0;
    while (!(cap_q.size() == 16 && bus.phy_wrin == bus.phy_wrout) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("drain_wait", n < 3000, 1);
    repeat (3) @(negedge clk);
    check("drain_n", cap_q.size(), 16);
    while (cap_q.size() > 0 && tx_exp.size() > 0) check("drain_word", cap_q.pop_front(), tx_exp.pop_front());
    check("din_stable", din_unstable, 0);
    cpu_write(2'd2, 16'h0014);
    cpu_read(2'd1, rd); check("drain_status", rd, 16'h0005);

    // Soft reset requested during TXWAIT
    cpu_write(2'd0, 16'h7777); tx_exp.push_back(16'h7777);
    n = 0;
    while (bus.phy_wrin == bus.phy_wrout && n < 20) begin @(negedge clk); n++; end
    check("srst_req_wait", n < 20, 1);
    cpu_write(2'd2, 16'h0011);
    check("srst_hold_off", bus.phy_soft_reset, 0);
    n = 0;
    while (bus.phy_wrin != bus.phy_wrout && n < 100) begin @(negedge clk); n++; end
    check("srst_ack_wait", n < 100, 1);
    check("srst_at_ack", bus.phy_soft_reset, 0);
    n = 0;
    while (!bus.phy_soft_reset && n < 10) begin @(negedge clk); n++; end
    check("srst_rise_wait", n < 10, 1);
    cpu_write(2'd0, 16'h9999);
    n = 0;
    while (bus.phy_soft_reset && n < 1000) begin @(negedge clk); n++; end
    check("srst_fall_wait", n < 1000, 1);
    check("srst_len", n_srst_hi, 255);
    repeat (3) @(negedge clk);
    check("srst_word", cap_q.pop_front(), tx_exp.pop_front());
    check("srst_no_more", cap_q.size(), 0);
    check("srst_sync", bus.phy_wrin == bus.phy_wrout, 1);
    cpu_read(2'd1, rd); check("srst_status", rd, 16'h0005);

    // Raw link status
    link_code = 16'hF080;
    repeat (2) @(negedge clk);
    cpu_read(2'd3, rd); check("link_attached", rd, 16'hF080);
    link_code = 16'h1E80;
    repeat (2) @(negedge clk);
    cpu_read(2'd3, rd); check("link_none", rd, 16'h1E80);

    // Asynchronous reset in RXWAIT
    rd_ack_en = 1'b0;
    cpu_write(2'd2, 16'h0012);
    n = 0;
    while (bus.phy_rdin == bus.phy_rdout && n < 20) begin @(negedge clk); n++; end
    check("ar_req_wait", n < 20, 1);
    check("ar_rdin_hi", bus.phy_rdin, 1);
    cpu_read(2'd1, rd);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_rdin", bus.phy_rdin, 0);
    check("ar_rdata", bus.rdata, 0);
    check("ar_din", bus.phy_din, 0);
    check("ar_irq", bus.irq, 0);
    check("ar_srst", bus.phy_soft_reset, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("ar_rdin_after", bus.phy_rdin, 0);
    cpu_read(2'd1, rd); check("ar_status", rd, 16'h0005);
    cpu_read(2'd2, rd); check("ar_ctrl", rd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
